// File: rtl/ones_frame_accum.sv
// Frame accumulator for 3-bit ones counts. It sums the counts over FRAME_LEN words,
// tracks the largest count and the number of all-ones words, then holds the result
// until the consumer takes it.
module ones_frame_accum #(
  parameter int FRAME_LEN = 8,
  parameter int ACC_W     = 6,
  parameter int CNT_W     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic [2:0]       max_cnt,
  output logic [CNT_W-1:0] full_hits
);

  if (FRAME_LEN < 2 || FRAME_LEN > 64) begin : g_bad_len
    $error("ones_frame_accum: FRAME_LEN must be in 2..64");
  end
  if ((2 ** ACC_W) <= 7 * FRAME_LEN) begin : g_bad_acc
    $error("ones_frame_accum: ACC_W too narrow for 7*FRAME_LEN");
  end
  if ((2 ** CNT_W) <= FRAME_LEN) begin : g_bad_cnt
    $error("ones_frame_accum: CNT_W too narrow for FRAME_LEN");
  end

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [2:0]       max_q, max_d;
  logic [CNT_W-1:0] hits_q, hits_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      idx_q   <= '0;
      sum_q   <= '0;
      max_q   <= '0;
      hits_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      hits_q  <= hits_d;
    end
  end

  // cnt is only looked at inside the accept branch, so X on an idle bus never leaks into state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    max_d   = max_q;
    hits_d  = hits_q;
    if (clear) begin
      state_d = ACCUM;
      idx_d   = '0;
      sum_d   = '0;
      max_d   = '0;
      hits_d  = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            sum_d  = sum_q + ACC_W'(cnt);
            max_d  = (cnt > max_q) ? cnt : max_q;
            hits_d = hits_q + {{(CNT_W-1){1'b0}}, (cnt == 3'd7)};
            idx_d  = idx_q + 1'b1;
            if (idx_q == CNT_W'(FRAME_LEN - 1)) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = ACCUM;
            idx_d   = '0;
            sum_d   = '0;
            max_d   = '0;
            hits_d  = '0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign sum       = sum_q;
  assign max_cnt   = max_q;
  assign full_hits = hits_q;

endmodule

// File: tb/tb_ones_frame_accum.sv
// Scoreboard bench for ones_frame_accum: directed frames plus random traffic,
// checked against a frame-level reference model.
module tb_ones_frame_accum;
  localparam int FRAME_LEN = 8;
  localparam int ACC_W     = 6;
  localparam int CNT_W     = 7;

  logic             clk = 1'b0;
  logic             rst, clear, in_valid, out_ready;
  logic [2:0]       cnt;
  logic             in_ready, out_valid;
  logic [ACC_W-1:0] sum;
  logic [2:0]       max_cnt;
  logic [CNT_W-1:0] full_hits;

  ones_frame_accum #(.FRAME_LEN(FRAME_LEN), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .cnt(cnt), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .max_cnt(max_cnt), .full_hits(full_hits)
  );

  always #5 clk = ~clk;

  typedef struct {int s; int m; int h;} res_t;

  res_t exp_q[$];
  int   words[$];
  bit   pending = 0;
  bit   started = 0;
  int   errors = 0;
  int   checks = 0;
  int   frames_out = 0;
  int   frames_exp = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t summarize(input int w[$]);
    res_t r;
    r.s = 0; r.m = 0; r.h = 0;
    foreach (w[i]) begin
      r.s += w[i];
      if (w[i] > r.m) r.m = w[i];
      if (w[i] == 7) r.h++;
    end
    return r;
  endfunction

  // Monitor: inputs are stable at the falling edge and apply at the next rising edge.
  always @(negedge clk) begin
    res_t r;
    if (started) begin
      check("in_ready", int'(in_ready), int'(!pending));
      check("out_valid", int'(out_valid), int'(pending));
      if (pending) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_nonempty", 0, 1);
        end else begin
          check("sum", int'(sum), exp_q[0].s);
          check("max_cnt", int'(max_cnt), exp_q[0].m);
          check("full_hits", int'(full_hits), exp_q[0].h);
        end
      end else begin
        r = summarize(words);
        check("partial_sum", int'(sum), r.s);
        check("partial_max", int'(max_cnt), r.m);
        check("partial_hits", int'(full_hits), r.h);
      end
    end
    if (rst || clear) begin
      if (pending && exp_q.size() > 0) void'(exp_q.pop_front());
      pending = 0;
      words.delete();
      if (rst) started = 1;
    end else if (started) begin
      if (pending) begin
        if (out_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          frames_out++;
          pending = 0;
        end
      end else if (in_valid) begin
        words.push_back(int'(cnt));
        if (words.size() == FRAME_LEN) begin
          exp_q.push_back(summarize(words));
          frames_exp++;
          words.delete();
          pending = 1;
        end
      end
    end
  end

  task automatic step(input logic v, input logic [2:0] c, input logic ordy, input logic clr);
    in_valid = v; cnt = c; out_ready = ordy; clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic frame_const(input logic [2:0] c, input logic ordy);
    for (int i = 0; i < FRAME_LEN; i++) step(1'b1, c, ordy, 1'b0);
  endtask

  task automatic ramp(input logic ordy);
    for (int i = 0; i < FRAME_LEN; i++) step(1'b1, 3'(i), ordy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b1; cnt = 3'd5; out_ready = 1'b0;
    step(1'b1, 3'd5, 1'b0, 1'b0);
    step(1'b1, 3'd5, 1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 3'bx, 1'b1, 1'b0);

    ramp(1'b1);
    step(1'b0, 3'bx, 1'b1, 1'b0);
    step(1'b0, 3'bx, 1'b1, 1'b0);

    frame_const(3'd7, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 3'd2, 1'b0, 1'b0);
    step(1'b0, 3'bx, 1'b1, 1'b0);
    step(1'b0, 3'bx, 1'b1, 1'b0);

    for (int i = 0; i < FRAME_LEN; i++) begin
      step(1'b1, 3'd3, 1'b1, 1'b0);
      step(1'b0, 3'bx, 1'b1, 1'b0);
    end
    step(1'b0, 3'bx, 1'b1, 1'b0);

    for (int i = 0; i < 3; i++) step(1'b1, 3'd6, 1'b1, 1'b0);
    step(1'b1, 3'd7, 1'b1, 1'b1);
    frame_const(3'd1, 1'b1);
    step(1'b0, 3'bx, 1'b1, 1'b0);

    ramp(1'b0);
    step(1'b0, 3'bx, 1'b0, 1'b0);
    step(1'b0, 3'bx, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b0, 3'bx, 1'b0, 1'b0);
    rst = 1'b0;
    ramp(1'b1);
    step(1'b0, 3'bx, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 59) == 0));
    for (int i = 0; i < 3; i++) step(1'b0, 3'bx, 1'b1, 1'b0);

    check("frames_delivered_min", int'(frames_out >= 6), 1);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
